mux_pipe_n: RTL and testbench

- Parametrised, registered successor to the single-bit ALU-source mux (ULASrc) in the nRisc datapath.
- Selects one of NSRC operand sources of WIDTH bits, e.g. register data, extended immediate, or forwarded results.
- Carries the result through a valid/ready pipeline stage with a 2-entry skid buffer, so the ALU-input stage can stall without losing operands.
- Flags out-of-range selects with a sticky error bit.

---
 rtl/mux_pipe_pkg.sv | 16 +
 rtl/mux_n.sv | 28 ++
 rtl/mux_pipe_n.sv | 102 ++++++++++
 tb/tb_mux_pipe_n.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pipe_pkg.sv
// Shared types and helpers for the registered N:1 operand mux stage.
package mux_pipe_pkg;

  // Occupancy of the main (M) and skid (S) registers.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  // Select width for a given source count; never below one bit.
  function automatic int sel_width(input int nsrc);
    return (nsrc > 1) ? $clog2(nsrc) : 1;
  endfunction

endpackage

// File: rtl/mux_n.sv
// Combinational NSRC:1 word mux with an out-of-range select flag.
module mux_n
  import mux_pipe_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int NSRC  = 4,
  localparam int SELW  = sel_width(NSRC)
) (
  input  logic [NSRC*WIDTH-1:0] data,
  input  logic [SELW-1:0]       sel,
  output logic [WIDTH-1:0]      word,
  output logic                  range_err
);

  // One bit wider than the select so NSRC itself is representable.
  localparam logic [SELW:0] LIMIT = (SELW + 1)'(NSRC);

  // Pick source k when sel == k; unmatched selects yield zero.
  always_comb begin
    word = '0;
    for (int k = 0; k < NSRC; k++) begin
      if (sel == SELW'(k)) word = data[k*WIDTH +: WIDTH];
    end
  end

  assign range_err = ({1'b0, sel} >= LIMIT);

endmodule

// File: rtl/mux_pipe_n.sv
// Registered operand-select stage: N:1 mux followed by a 2-entry
// valid/ready skid buffer so the consumer can stall without losing beats.
module mux_pipe_n
  import mux_pipe_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int NSRC  = 4,
  localparam int SELW  = sel_width(NSRC)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NSRC*WIDTH-1:0] in_data,
  input  logic [SELW-1:0]       in_sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [SELW-1:0]       out_sel,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  sel_err
);

  state_t           state;
  logic [WIDTH-1:0] mux_word;
  logic             mux_err;
  logic [WIDTH-1:0] skid_data;
  logic [SELW-1:0]  skid_sel;
  logic             acc;
  logic             con;

  mux_n #(
    .WIDTH (WIDTH),
    .NSRC  (NSRC)
  ) u_mux (
    .data      (in_data),
    .sel       (in_sel),
    .word      (mux_word),
    .range_err (mux_err)
  );

  assign acc = in_valid && in_ready;
  assign con = out_valid && out_ready;

  // Skid FSM: tracks occupancy and owns the output register, ready and sticky error.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      out_data  <= '0;
      out_sel   <= '0;
      sel_err   <= 1'b0;
    end else begin
      if (acc && mux_err) sel_err <= 1'b1;
      case (state)
        EMPTY: begin
          if (acc) begin
            state     <= ONE;
            out_valid <= 1'b1;
            out_data  <= mux_word;
            out_sel   <= in_sel;
          end
        end
        ONE: begin
          if (acc && con) begin
            out_data <= mux_word;
            out_sel  <= in_sel;
          end else if (acc) begin
            // New beat parks in S; stop accepting until the consumer drains M.
            state    <= FULL;
            in_ready <= 1'b0;
          end else if (con) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
          end
        end
        FULL: begin
          if (con) begin
            state    <= ONE;
            in_ready <= 1'b1;
            out_data <= skid_data;
            out_sel  <= skid_sel;
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

  // Skid register: captures the beat that arrives while the output is stalled.
  always_ff @(posedge clock) begin
    if (state == ONE && acc && !con) begin
      skid_data <= mux_word;
      skid_sel  <= in_sel;
    end
  end

endmodule

// File: tb/tb_mux_pipe_n.sv
// Bench for mux_pipe_n: three instances (8x4, 8x3, 16x8) checked every cycle
// against a 2-deep FIFO model, plus literal expectations for directed vectors.
module tb_mux_pipe_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [127:0] src    [3];
  logic [2:0]   sel_in [3];
  logic         vin    [3];
  logic         ordy   [3];

  logic [7:0]   od0, od1;
  logic [15:0]  od2;
  logic [1:0]   os0, os1;
  logic [2:0]   os2;
  logic         ov [3];
  logic         ir [3];
  logic         se [3];

  logic [15:0]  act_d [3];
  logic [2:0]   act_s [3];

  mux_pipe_n #(.WIDTH(8), .NSRC(4)) u0 (
    .clock(clk), .reset(rst), .in_data(src[0][31:0]), .in_sel(sel_in[0][1:0]),
    .in_valid(vin[0]), .in_ready(ir[0]), .out_data(od0), .out_sel(os0),
    .out_valid(ov[0]), .out_ready(ordy[0]), .sel_err(se[0]));

  mux_pipe_n #(.WIDTH(8), .NSRC(3)) u1 (
    .clock(clk), .reset(rst), .in_data(src[1][23:0]), .in_sel(sel_in[1][1:0]),
    .in_valid(vin[1]), .in_ready(ir[1]), .out_data(od1), .out_sel(os1),
    .out_valid(ov[1]), .out_ready(ordy[1]), .sel_err(se[1]));

  mux_pipe_n #(.WIDTH(16), .NSRC(8)) u2 (
    .clock(clk), .reset(rst), .in_data(src[2]), .in_sel(sel_in[2]),
    .in_valid(vin[2]), .in_ready(ir[2]), .out_data(od2), .out_sel(os2),
    .out_valid(ov[2]), .out_ready(ordy[2]), .sel_err(se[2]));

  assign act_d[0] = {8'h00, od0};
  assign act_d[1] = {8'h00, od1};
  assign act_d[2] = od2;
  assign act_s[0] = {1'b0, os0};
  assign act_s[1] = {1'b0, os1};
  assign act_s[2] = os2;

  int total = 0;
  int bad   = 0;
  bit run   = 1'b0;

  // Model state: contents of a 2-deep FIFO per instance, oldest at index 0.
  logic [15:0] m_data [3][2];
  logic [2:0]  m_sel  [3][2];
  int          m_cnt  [3];
  logic        m_err  [3];

  function automatic int w_of(input int id);
    return (id == 2) ? 16 : 8;
  endfunction

  function automatic int n_of(input int id);
    case (id)
      0:       return 4;
      1:       return 3;
      default: return 8;
    endcase
  endfunction

  function automatic logic [15:0] pick(input int id, input logic [127:0] d, input logic [2:0] s);
    logic [127:0] sh;
    if (int'(s) >= n_of(id)) return 16'h0000;
    sh = d >> (int'(s) * w_of(id));
    return sh[15:0] & 16'((32'd1 << w_of(id)) - 1);
  endfunction

  task automatic chk(input string name, input int id, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[u%0d] got=%h want=%h at %0t", name, id, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Model update on each rising edge: pop on consume, push on accept.
  initial begin
    for (int id = 0; id < 3; id++) begin
      m_cnt[id] = 0;
      m_err[id] = 1'b0;
    end
    forever begin
      @(posedge clk);
      for (int id = 0; id < 3; id++) begin
        if (rst) begin
          m_cnt[id] = 0;
          m_err[id] = 1'b0;
        end else begin
          bit acc_m;
          bit con_m;
          acc_m = vin[id] && (m_cnt[id] < 2);
          con_m = ordy[id] && (m_cnt[id] > 0);
          if (con_m) begin
            m_data[id][0] = m_data[id][1];
            m_sel[id][0]  = m_sel[id][1];
            m_cnt[id]--;
          end
          if (acc_m) begin
            m_data[id][m_cnt[id]] = pick(id, src[id], sel_in[id]);
            m_sel[id][m_cnt[id]]  = sel_in[id];
            m_cnt[id]++;
            if (int'(sel_in[id]) >= n_of(id)) m_err[id] = 1'b1;
          end
        end
      end
    end
  end

  // Per-cycle compare of every instance against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (run) begin
        for (int id = 0; id < 3; id++) begin
          chk("out_valid", id, {15'd0, ov[id]}, {15'd0, m_cnt[id] > 0});
          chk("in_ready",  id, {15'd0, ir[id]}, {15'd0, m_cnt[id] < 2});
          chk("sel_err",   id, {15'd0, se[id]}, {15'd0, m_err[id]});
          if (m_cnt[id] > 0) begin
            chk("out_data", id, act_d[id], m_data[id][0]);
            chk("out_sel",  id, {13'd0, act_s[id]}, {13'd0, m_sel[id][0]});
          end
        end
      end
    end
  end

  // Directed stimulus with literal expectations, then a random sweep.
  initial begin
    logic [7:0] exp_s [4];
    exp_s[0] = 8'h11; exp_s[1] = 8'h2D; exp_s[2] = 8'hA5; exp_s[3] = 8'h7F;
    rst = 1'b1;
    for (int id = 0; id < 3; id++) begin
      src[id] = '0; sel_in[id] = '0; vin[id] = 1'b0; ordy[id] = 1'b1;
    end
    src[0] = 128'h7FA52D11;
    src[1] = 128'hA52D11;
    step(); step();
    rst = 1'b0;
    run = 1'b1;

    // Reset state
    chk("rst_valid", 0, {15'd0, ov[0]}, 16'd0);
    chk("rst_ready", 0, {15'd0, ir[0]}, 16'd1);
    chk("rst_data",  0, act_d[0], 16'h0000);
    chk("rst_err",   0, {15'd0, se[0]}, 16'd0);

    // Basic select
    sel_in[0] = 3'd1; vin[0] = 1'b1;
    step();
    vin[0] = 1'b0;
    chk("basic_data",  0, act_d[0], 16'h002D);
    chk("basic_sel",   0, {13'd0, act_s[0]}, 16'd1);
    chk("basic_valid", 0, {15'd0, ov[0]}, 16'd1);
    step();

    // Streaming
    for (int i = 0; i < 4; i++) begin
      sel_in[0] = 3'(i); vin[0] = 1'b1;
      step();
      chk("stream_data",  0, act_d[0], {8'h00, exp_s[i]});
      chk("stream_ready", 0, {15'd0, ir[0]}, 16'd1);
    end
    vin[0] = 1'b0;
    step();

    // Stall and skid
    ordy[0] = 1'b0;
    sel_in[0] = 3'd2; vin[0] = 1'b1;
    step();
    chk("stall_data1", 0, act_d[0], 16'h00A5);
    sel_in[0] = 3'd3;
    step();
    chk("stall_data2",  0, act_d[0], 16'h00A5);
    chk("stall_ready0", 0, {15'd0, ir[0]}, 16'd0);
    sel_in[0] = 3'd0;
    step();
    chk("stall_hold",   0, act_d[0], 16'h00A5);
    chk("stall_ready1", 0, {15'd0, ir[0]}, 16'd0);
    vin[0] = 1'b0; ordy[0] = 1'b1;
    step();
    chk("drain_data",  0, act_d[0], 16'h007F);
    chk("drain_ready", 0, {15'd0, ir[0]}, 16'd1);
    step();
    chk("drain_empty", 0, {15'd0, ov[0]}, 16'd0);

    // Out-of-range select on the 3-source instance
    sel_in[1] = 3'd3; vin[1] = 1'b1;
    step();
    chk("oor_data", 1, act_d[1], 16'h0000);
    chk("oor_err",  1, {15'd0, se[1]}, 16'd1);
    sel_in[1] = 3'd0;
    step();
    vin[1] = 1'b0;
    chk("oor_next_data", 1, act_d[1], 16'h0011);
    chk("oor_sticky1",   1, {15'd0, se[1]}, 16'd1);
    step();
    chk("oor_sticky2",   1, {15'd0, se[1]}, 16'd1);

    // Reset while FULL
    ordy[0] = 1'b0;
    sel_in[0] = 3'd0; vin[0] = 1'b1;
    step();
    sel_in[0] = 3'd1;
    step();
    chk("pre_rst_ready", 0, {15'd0, ir[0]}, 16'd0);
    rst = 1'b1; sel_in[0] = 3'd2;
    step();
    rst = 1'b0; vin[0] = 1'b0; ordy[0] = 1'b1;
    chk("mrst_valid", 0, {15'd0, ov[0]}, 16'd0);
    chk("mrst_ready", 0, {15'd0, ir[0]}, 16'd1);
    chk("mrst_err",   1, {15'd0, se[1]}, 16'd0);
    chk("mrst_data",  0, act_d[0], 16'h0000);
    sel_in[0] = 3'd3; vin[0] = 1'b1;
    step();
    vin[0] = 1'b0;
    chk("post_rst_data",  0, act_d[0], 16'h007F);
    chk("post_rst_valid", 0, {15'd0, ov[0]}, 16'd1);
    step();
    chk("post_rst_empty", 0, {15'd0, ov[0]}, 16'd0);

    // Random valid/ready sweep on the 16x8 instance
    for (int c = 0; c < 400; c++) begin
      vin[2]    = 1'($urandom_range(0, 1));
      ordy[2]   = ($urandom_range(0, 3) != 0);
      sel_in[2] = 3'($urandom_range(0, 7));
      src[2]    = {$urandom(), $urandom(), $urandom(), $urandom()};
      step();
    end
    vin[2] = 1'b0; ordy[2] = 1'b1;
    step(); step(); step();
    chk("sweep_drained", 2, {15'd0, ov[2]}, 16'd0);
    chk("sweep_err",     2, {15'd0, se[2]}, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
